// File: rtl/cic_rate_ctl_if.sv
// Register-write bus and sequencer outputs of the CIC rate controller.
// The controller is the slave: it takes writes and drives enables and configuration.
interface cic_rate_ctl_if;
   logic        wr;
   logic        wa;
   logic [15:0] wd;
   logic        cea;
   logic        ceb;
   logic [4:0]  ge;
   logic [9:0]  gf;
   logic        c;
   logic        xmt;
   logic        cic_rst;
   logic        busy;
   logic        fsync;

   modport master (
      output wr, wa, wd,
      input  cea, ceb, ge, gf, c, xmt, cic_rst, busy, fsync
   );

   modport slave (
      input  wr, wa, wd,
      output cea, ceb, ge, gf, c, xmt, cic_rst, busy, fsync
   );
endinterface

// File: rtl/cic_rate_ctl.sv
// Enable sequencer and config owner for the dual-channel CIC; all outputs registered.
// Writes are always accepted; mode changes run drain -> filter reset -> load before taking effect.
module cic_rate_ctl #(
   parameter int RMIN         = 8,
   parameter int FLUSH_CYCLES = 20,
   parameter int RST_CYCLES   = 4
) (
   input logic           clk,
   input logic           rst,
   cic_rate_ctl_if.slave bus
);
   localparam int TMAX = (FLUSH_CYCLES > RST_CYCLES) ? FLUSH_CYCLES : RST_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);
   localparam logic [11:0]   RMIN_V     = 12'(RMIN);
   localparam logic [TW-1:0] DRAIN_LAST = TW'(FLUSH_CYCLES - 1);
   localparam logic [TW-1:0] RST_LAST   = TW'(RST_CYCLES - 1);

   typedef enum logic [1:0] {S_RUN, S_DRAIN, S_RESET, S_LOAD} state_t;

   state_t        state, state_nxt;
   logic [TW-1:0] tmr, tmr_nxt;
   logic [12:0]   cnt, cnt_nxt, per;
   logic          pend, pend_nxt;
   logic [14:0]   gsh, gsh_nxt;
   logic [13:0]   msh, msh_nxt;
   logic [11:0]   rate, rate_nxt;
   logic          c_q, c_nxt, xmt_q, xmt_nxt;
   logic [4:0]    ge_q, ge_nxt;
   logic [9:0]    gf_q, gf_nxt;
   logic          cea_q, cea_nxt, ceb_q, ceb_nxt;
   logic          cic_rst_q, cic_rst_nxt, busy_q, busy_nxt;
   logic          apply_wr, gain_upd;

   always_ff @(posedge clk) begin
      if (rst) state <= S_RESET;
      else     state <= state_nxt;
   end

   always_comb begin
      // Forwarded shadows: a write on the load/wrap clock is seen immediately
      gsh_nxt   = (bus.wr && !bus.wa) ? bus.wd[14:0] : gsh;
      msh_nxt   = (bus.wr &&  bus.wa) ? bus.wd[13:0] : msh;
      apply_wr  = bus.wr && bus.wa && bus.wd[15];
      per       = c_q ? {rate, 1'b0} : {1'b0, rate};
      state_nxt = state;
      tmr_nxt   = tmr;
      cnt_nxt   = cnt;
      pend_nxt  = pend | apply_wr;
      rate_nxt  = rate;
      c_nxt     = c_q;
      xmt_nxt   = xmt_q;
      gain_upd  = 1'b0;
      case (state)
         S_RUN: begin
            if (pend) begin
               state_nxt = S_DRAIN;
               tmr_nxt   = '0;
               pend_nxt  = apply_wr;
            end else begin
               cnt_nxt  = (cnt == per - 13'd1) ? 13'd0 : cnt + 13'd1;
               gain_upd = (cnt == per - 13'd1);
            end
         end
         S_DRAIN: begin
            if (tmr == DRAIN_LAST) begin
               state_nxt = S_RESET;
               tmr_nxt   = '0;
            end else begin
               tmr_nxt = tmr + TW'(1);
            end
         end
         S_RESET: begin
            if (tmr == RST_LAST) begin
               state_nxt = S_LOAD;
               tmr_nxt   = '0;
            end else begin
               tmr_nxt = tmr + TW'(1);
            end
         end
         S_LOAD: begin
            rate_nxt = (msh_nxt[11:0] < RMIN_V) ? RMIN_V : msh_nxt[11:0];
            c_nxt    = msh_nxt[12];
            xmt_nxt  = msh_nxt[13];
            gain_upd = 1'b1;
            cnt_nxt  = '0;
            // A re-armed apply goes straight back to draining, never enabling in between
            if (pend || apply_wr) begin
               state_nxt = S_DRAIN;
               pend_nxt  = 1'b0;
            end else begin
               state_nxt = S_RUN;
            end
         end
         default: state_nxt = S_RESET;
      endcase
      ge_nxt      = gain_upd ? gsh_nxt[14:10] : ge_q;
      gf_nxt      = gain_upd ? gsh_nxt[9:0]   : gf_q;
      busy_nxt    = (state_nxt != S_RUN);
      cic_rst_nxt = (state_nxt == S_RESET);
      cea_nxt     = (state_nxt == S_RUN) && (cnt_nxt == 13'd0);
      ceb_nxt     = (state_nxt == S_RUN) && c_nxt && (cnt_nxt == 13'd1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tmr       <= '0;
         cnt       <= '0;
         pend      <= 1'b0;
         gsh       <= {5'd0, 10'h040};
         msh       <= {2'b00, RMIN_V};
         rate      <= RMIN_V;
         c_q       <= 1'b0;
         xmt_q     <= 1'b0;
         ge_q      <= 5'd0;
         gf_q      <= 10'h040;
         cea_q     <= 1'b0;
         ceb_q     <= 1'b0;
         cic_rst_q <= 1'b1;
         busy_q    <= 1'b1;
      end else begin
         tmr       <= tmr_nxt;
         cnt       <= cnt_nxt;
         pend      <= pend_nxt;
         gsh       <= gsh_nxt;
         msh       <= msh_nxt;
         rate      <= rate_nxt;
         c_q       <= c_nxt;
         xmt_q     <= xmt_nxt;
         ge_q      <= ge_nxt;
         gf_q      <= gf_nxt;
         cea_q     <= cea_nxt;
         ceb_q     <= ceb_nxt;
         cic_rst_q <= cic_rst_nxt;
         busy_q    <= busy_nxt;
      end
   end

   assign bus.cea     = cea_q;
   assign bus.fsync   = cea_q;
   assign bus.ceb     = ceb_q;
   assign bus.ge      = ge_q;
   assign bus.gf      = gf_q;
   assign bus.c       = c_q;
   assign bus.xmt     = xmt_q;
   assign bus.cic_rst = cic_rst_q;
   assign bus.busy    = busy_q;
endmodule

// File: tb/tb_cic_rate_ctl.sv
// Bench for cic_rate_ctl: table of mode applies plus hand-written gain, double-apply
// and mid-sequence reset cases; expected sequence shapes queued at stimulus time.
module tb_cic_rate_ctl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cic_rate_ctl_if bus();

   cic_rate_ctl #(.RMIN(8), .FLUSH_CYCLES(20), .RST_CYCLES(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [11:0] rate;
      bit          c;
      bit          xmt;
      int          per;
      int          cebpos;
   } vec_t;

   typedef struct {
      int pre;
      int nrst;
      int nbusy;
      int npulse;
      int per;
      int cebpos;
      int c;
      int xmt;
   } exp_t;

   exp_t exp_q[$];
   vec_t vt[4];
   int   nchk = 0;
   int   nerr = 0;
   int   m_pre, m_nrst, m_nbusy, m_npulse, m_bad, m_ok;
   int   p_per, p_ceb, p_bad;

   task automatic chk(input string name, input int act, input int exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic wr_reg(input bit a, input logic [15:0] d);
      @(posedge clk); #1;
      bus.wr = 1'b1; bus.wa = a; bus.wd = d;
      @(posedge clk); #1;
      bus.wr = 1'b0;
   endtask

   function automatic logic [15:0] mode_word(input logic [11:0] r, input bit cc, input bit x, input bit ap);
      return {ap, 1'b0, x, cc, r};
   endfunction

   // Walks a busy window: drain cycles before the first cic_rst, cic_rst cycles,
   // reset pulses, total busy cycles, and any enable seen while busy.
   task automatic measure_seq(input bit now);
      int budget = 400;
      bit first = 1'b1;
      bit seen = 1'b0;
      bit prev = 1'b0;
      m_pre = 0; m_nrst = 0; m_nbusy = 0; m_npulse = 0; m_bad = 0; m_ok = 0;
      while (budget > 0) begin
         if (!(first && now)) @(negedge clk);
         first = 1'b0;
         budget--;
         if (!bus.busy) begin
            if (seen) begin
               m_ok = int'(bus.cea);
               break;
            end
            continue;
         end
         seen = 1'b1;
         m_nbusy++;
         if (bus.cea || bus.ceb || bus.fsync) m_bad++;
         if (bus.cic_rst) begin
            m_nrst++;
            if (!prev) m_npulse++;
         end else if (m_npulse == 0) begin
            m_pre++;
         end
         prev = bus.cic_rst;
      end
   endtask

   // From a cea cycle, measures the distance to the next cea and where ceb fell.
   task automatic measure_period();
      p_per = -1; p_ceb = -1; p_bad = 0;
      if (!bus.cea || !bus.fsync) p_bad++;
      for (int k = 1; k <= 600; k++) begin
         @(negedge clk);
         if (bus.fsync !== bus.cea) p_bad++;
         if (bus.cea && bus.ceb) p_bad++;
         if (bus.busy) p_bad++;
         if (bus.ceb && p_ceb < 0) p_ceb = k;
         if (bus.cea) begin
            p_per = k;
            break;
         end
      end
   endtask

   task automatic check_seq(input string tag);
      exp_t e;
      if (exp_q.size() == 0) begin
         nchk++; nerr++;
         $display("FAIL %s: scoreboard empty, got nothing expected an entry", tag);
         return;
      end
      e = exp_q.pop_front();
      chk({tag, ".first_cea"}, m_ok, 1);
      chk({tag, ".drain"},     m_pre, e.pre);
      chk({tag, ".rst_cyc"},   m_nrst, e.nrst);
      chk({tag, ".busy_cyc"},  m_nbusy, e.nbusy);
      chk({tag, ".rst_pulse"}, m_npulse, e.npulse);
      chk({tag, ".ce_in_busy"}, m_bad, 0);
      measure_period();
      chk({tag, ".period"},    p_per, e.per);
      chk({tag, ".ceb_pos"},   p_ceb, e.cebpos);
      chk({tag, ".run_viol"},  p_bad, 0);
      chk({tag, ".c"},         int'(bus.c), e.c);
      chk({tag, ".xmt"},       int'(bus.xmt), e.xmt);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int t, oldbad, nb, w;
      bus.wr = 1'b0; bus.wa = 1'b0; bus.wd = '0;
      vt[0] = '{12'd100, 1'b1, 1'b0, 200, 1};
      vt[1] = '{12'd3,   1'b0, 1'b0, 8,   -1};
      vt[2] = '{12'd9,   1'b1, 1'b0, 18,  1};
      vt[3] = '{12'd50,  1'b0, 1'b1, 50,  -1};

      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst.cic_rst", int'(bus.cic_rst), 1);
      chk("rst.busy",    int'(bus.busy), 1);
      chk("rst.cea",     int'(bus.cea), 0);
      chk("rst.ceb",     int'(bus.ceb), 0);
      chk("rst.fsync",   int'(bus.fsync), 0);
      chk("rst.ge",      int'(bus.ge), 0);
      chk("rst.gf",      int'(bus.gf), 'h040);
      chk("rst.c",       int'(bus.c), 0);
      chk("rst.xmt",     int'(bus.xmt), 0);

      @(posedge clk); #1 rst = 1'b0;
      exp_q.push_back('{0, 4, 5, 1, 8, -1, 0, 0});
      measure_seq(1'b0);
      check_seq("por");
      chk("por.ge", int'(bus.ge), 0);
      chk("por.gf", int'(bus.gf), 'h040);

      for (int i = 0; i < 4; i++) begin
         wr_reg(1'b1, mode_word(vt[i].rate, vt[i].c, vt[i].xmt, 1'b1));
         exp_q.push_back('{20, 4, 25, 1, vt[i].per, vt[i].cebpos, int'(vt[i].c), int'(vt[i].xmt)});
         measure_seq(1'b0);
         check_seq($sformatf("vec%0d", i));
      end

      // Gain written mid-frame takes effect exactly on the next cea.
      repeat (2) @(posedge clk);
      wr_reg(1'b0, {1'b0, 5'd12, 10'h080});
      oldbad = 0;
      for (t = 4; t <= 60; t++) begin
         @(negedge clk);
         if (bus.cea) break;
         if (bus.ge != 5'd0 || bus.gf != 10'h040 || bus.busy) oldbad++;
      end
      chk("gain.cea_spacing", t, 50);
      chk("gain.held_before", oldbad, 0);
      chk("gain.ge", int'(bus.ge), 12);
      chk("gain.gf", int'(bus.gf), 'h080);

      // Gain write landing on the wrap clock is used at that wrap.
      repeat (48) @(posedge clk);
      wr_reg(1'b0, {1'b0, 5'd5, 10'h155});
      @(negedge clk);
      chk("wrapgain.cea", int'(bus.cea), 1);
      chk("wrapgain.ge",  int'(bus.ge), 5);
      chk("wrapgain.gf",  int'(bus.gf), 'h155);

      // Mode write without apply only touches the shadow.
      wr_reg(1'b1, mode_word(12'd12, 1'b1, 1'b0, 1'b0));
      nb = 0;
      repeat (30) begin
         @(negedge clk);
         if (bus.busy || bus.c) nb++;
      end
      chk("noapply.untouched", nb, 0);

      // Second apply during the first drain: two back-to-back sequences.
      wr_reg(1'b1, mode_word(12'd40, 1'b0, 1'b1, 1'b1));
      exp_q.push_back('{20, 8, 50, 2, 20, -1, 0, 1});
      fork
         measure_seq(1'b0);
         begin
            repeat (5) @(posedge clk);
            wr_reg(1'b1, mode_word(12'd20, 1'b0, 1'b1, 1'b1));
         end
      join
      check_seq("dbl");
      chk("dbl.ge", int'(bus.ge), 5);
      chk("dbl.gf", int'(bus.gf), 'h155);

      // Reset while the filter reset is in progress, with xmt=1 active.
      wr_reg(1'b1, mode_word(12'd30, 1'b1, 1'b1, 1'b1));
      for (w = 0; w < 60; w++) begin
         @(negedge clk);
         if (bus.cic_rst) break;
      end
      chk("midrst.reached_reset", int'(w < 60), 1);
      chk("midrst.xmt_before", int'(bus.xmt), 1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("midrst.xmt",     int'(bus.xmt), 0);
      chk("midrst.cic_rst", int'(bus.cic_rst), 1);
      chk("midrst.busy",    int'(bus.busy), 1);
      chk("midrst.cea",     int'(bus.cea), 0);
      chk("midrst.ge",      int'(bus.ge), 0);
      chk("midrst.gf",      int'(bus.gf), 'h040);
      exp_q.push_back('{0, 4, 5, 1, 8, -1, 0, 0});
      measure_seq(1'b1);
      check_seq("midrst");

      chk("scoreboard.drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
